pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

- Central stall/flush controller for the 5-stage pipeline.
- Resolves the hazards that forwarding cannot:
  - load-use RAW, where EX holds a load whose data is not yet available;
  - multi-cycle divide occupying EX;
  - data-memory wait states in MEM;
  - taken-branch redirect from EX.
- Drives per-register hold and bubble controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Keeps stall statistics and a memory-timeout flag.

## Interface
Parameters:
- CNT_W, 32, width of stall cycle counter
- MEM_TIMEOUT, 255, consecutive MEM wait cycles before timeout flag sets (>=1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- rs1_re_id_i  in  1  ID reads rs1
- rs1_addr_id_i  in  5  ID rs1 index
- rs2_re_id_i  in  1  ID reads rs2
- rs2_addr_id_i  in  5  ID rs2 index
- rd_we_ex_i  in  1  EX instruction writes rd
- rd_addr_ex_i  in  5  EX rd index
- mem_re_ex_i  in  1  EX instruction is a load
- div_start_ex_i  in  1  EX issues a divide this cycle (single-cycle pulse)
- div_done_i  in  1  divider result valid this cycle (pulse)
- mem_req_mem_i  in  1  MEM stage has a data-memory access
- mem_ready_i  in  1  data memory completes access this cycle
- branch_taken_ex_i  in  1  EX resolves taken branch/jump
- stall_o  out  5  hold enables: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB
- flush_ifid_o  out  1  load bubble (NOP) into IF/ID
- flush_idex_o  out  1  load bubble into ID/EX
- flush_exmem_o  out  1  load bubble into EX/MEM
- flush_memwb_o  out  1  load bubble into MEM/WB
- stall_cnt_o  out  CNT_W  cycles with stall_o[0]=1, saturating
- mem_timeout_o  out  1  sticky timeout flag

## Operation
- State register: RUN or DIV_BUSY.
  - RUN -> DIV_BUSY on div_start_ex_i=1 while EX is not stalled by MEM wait.
  - DIV_BUSY -> RUN on div_done_i=1.
  - div_done_i in RUN is ignored.
  - div_start_ex_i in DIV_BUSY is ignored.
- Conditions, all combinational from inputs plus registered state:
  - memw = mem_req_mem_i & ~mem_ready_i
  - divw = (div_start_ex_i | state==DIV_BUSY) & ~div_done_i
  - lu = mem_re_ex_i & rd_we_ex_i & rd_addr_ex_i!=0 & ((rs1_re_id_i & rs1_addr_id_i==rd_addr_ex_i) | (rs2_re_id_i & rs2_addr_id_i==rd_addr_ex_i))
  - br = branch_taken_ex_i
- Outputs are resolved in priority order; the first matching case applies:
  - memw: stall_o=5'b01111, flush_memwb_o=1, all other flushes 0.
  - divw: stall_o=5'b00111, flush_exmem_o=1.
  - br: stall_o=0, flush_ifid_o=1, flush_idex_o=1. A branch outranks a load-use on a wrong-path instruction.
  - lu: stall_o=5'b00011, flush_idex_o=1.
  - Otherwise all stall and flush outputs are 0.
- A hold (stall bit) and a bubble (flush) are never both asserted on the same pipeline register.
- stall_cnt_o increments when stall_o[0]=1 and saturates at all-ones.
- Timeout counter:
  - counts consecutive memw cycles and clears when memw=0;
  - when it reaches MEM_TIMEOUT, mem_timeout_o sets;
  - mem_timeout_o stays set until reset; the pipeline keeps waiting after it sets.

## Timing
- Stall and flush outputs are zero-latency combinational, valid in the same cycle as their causes.
- State, stall_cnt_o, the timeout counter and mem_timeout_o update on the rising clk edge.
- Load-use costs exactly 1 bubble cycle. On the next cycle the load is in MEM, lu=0, and forwarding supplies the data.
- Divide started in cycle T with done in cycle T+k (k>=1):
  - stall_o=5'b00111 in cycles T..T+k-1;
  - cycle T+k is unstalled and EX/MEM captures the result.
- While rst_n=0 (sampled), all stall and flush outputs are 0.
- Reset state:
  - state=RUN;
  - stall_cnt_o=0, timeout counter=0, mem_timeout_o=0 after the edge.
- Reset mid-divide returns to RUN; a later div_done_i is ignored.
- Simultaneous causes:
  - memw together with divw: memw wins and state is held. DIV_BUSY is retained and div_done_i is still honored, so the done-transition occurs.
  - memw together with br: branch flushes are suppressed. The branch stays in EX, is re-presented when MEM frees, and flushes then.
- MEM_TIMEOUT=1: mem_timeout_o sets after the first wait cycle.

## Test plan
- Load-use: EX lw rd=5, ID add reading rs1=5.
  - Required: one cycle of stall_o=00011, flush_idex_o=1, then 0.
  - stall_cnt_o goes 0->1.
- rd=x0 load and rs1=0: no stall.
  - rs2 match with rs2_re_id_i=0: no stall.
- Divide: start at T, done at T+4.
  - stall_o=00111 and flush_exmem_o=1 for T..T+3.
  - Unstalled at T+4; state returns to RUN.
- Branch plus load-use in the same cycle: flush_ifid_o=flush_idex_o=1, stall_o=0.
- MEM wait of 3 cycles during a divide in EX, with div_done_i in the 2nd wait cycle:
  - stall_o=01111 for 3 cycles;
  - state is RUN afterwards.
- MEM_TIMEOUT=4 with 5 wait cycles:
  - mem_timeout_o=1 from the edge ending the 4th wait cycle and stays 1 afterwards;
  - rst_n=0 clears it and stall_cnt_o.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard inputs from the pipeline and the stall/flush controls returned to it
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 32);
  logic             rs1_re_id;
  logic [4:0]       rs1_addr_id;
  logic             rs2_re_id;
  logic [4:0]       rs2_addr_id;
  logic             rd_we_ex;
  logic [4:0]       rd_addr_ex;
  logic             mem_re_ex;
  logic             div_start_ex;
  logic             div_done;
  logic             mem_req_mem;
  logic             mem_ready;
  logic             branch_taken_ex;
  logic [4:0]       stall;
  logic             flush_ifid;
  logic             flush_idex;
  logic             flush_exmem;
  logic             flush_memwb;
  logic [CNT_W-1:0] stall_cnt;
  logic             mem_timeout;
  modport master (
    output rs1_re_id, rs1_addr_id, rs2_re_id, rs2_addr_id, rd_we_ex, rd_addr_ex,
           mem_re_ex, div_start_ex, div_done, mem_req_mem, mem_ready, branch_taken_ex,
    input  stall, flush_ifid, flush_idex, flush_exmem, flush_memwb, stall_cnt, mem_timeout
  );
  modport slave (
    input  rs1_re_id, rs1_addr_id, rs2_re_id, rs2_addr_id, rd_we_ex, rd_addr_ex,
           mem_re_ex, div_start_ex, div_done, mem_req_mem, mem_ready, branch_taken_ex,
    output stall, flush_ifid, flush_idex, flush_exmem, flush_memwb, stall_cnt, mem_timeout
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush controller for load-use, divide, MEM wait and branch hazards
module pipe_hazard_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipe_hazard_ctrl_if.slave     bus
);
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TLIM = TW'(MEM_TIMEOUT);
  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] DIV_BUSY = 1'b1;
  logic [0:0]    state;
  logic [TW-1:0] tcnt;
  logic          memw, divw, lu, br;
  logic [8:0]    ctl;
  always_comb begin
    memw = bus.mem_req_mem & ~bus.mem_ready;
    divw = (bus.div_start_ex | (state == DIV_BUSY)) & ~bus.div_done;
    lu   = bus.mem_re_ex & bus.rd_we_ex & (bus.rd_addr_ex != 5'd0) &
           ((bus.rs1_re_id & (bus.rs1_addr_id == bus.rd_addr_ex)) |
            (bus.rs2_re_id & (bus.rs2_addr_id == bus.rd_addr_ex)));
    br   = bus.branch_taken_ex;
    // {stall[4:0], flush_ifid, flush_idex, flush_exmem, flush_memwb}
    ctl  = !rst_n ? 9'b0 :
           memw   ? {5'b01111, 4'b0001} :
           divw   ? {5'b00111, 4'b0010} :
           br     ? {5'b00000, 4'b1100} :
           lu     ? {5'b00011, 4'b0100} : 9'b0;
  end
  assign {bus.stall, bus.flush_ifid, bus.flush_idex, bus.flush_exmem, bus.flush_memwb} = ctl;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= RUN;
      bus.stall_cnt   <= '0;
      tcnt            <= '0;
      bus.mem_timeout <= 1'b0;
    end else begin
      state <= (state == DIV_BUSY) ? (bus.div_done ? RUN : DIV_BUSY)
                                   : ((bus.div_start_ex & ~memw) ? DIV_BUSY : RUN);
      if (ctl[4] && !(&bus.stall_cnt)) bus.stall_cnt <= bus.stall_cnt + 1'b1;
      tcnt <= memw ? ((tcnt == TLIM) ? tcnt : tcnt + 1'b1) : '0;
      if (memw && (tcnt == TLIM - 1'b1)) bus.mem_timeout <= 1'b1;
    end
  end
endmodule
